// File: rtl/fir_stream_controller_pkg.sv
// ----------------------------------------------------------------------------
// fir_stream_controller_pkg
//
// Purpose : shared types for the FIR run sequencer. Holds the controller state
//           encoding and a helper that derives how many zero pads a full
//           convolution needs for a given tap count.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package fir_stream_controller_pkg;

    // One FIR run walks IDLE -> (COEFF) -> STREAM -> PAD -> DRAIN -> DONE -> IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COEFF  = 3'd1,
        STREAM = 3'd2,
        PAD    = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } fir_ctrl_state_e;

    // A LENGTH-tap filter needs LENGTH-1 trailing zeros to flush every
    // convolution term; a single-tap filter needs none.
    function automatic int padCycles(input int length);
        return (length > 1) ? length - 1 : 0;
    endfunction

endpackage

// File: rtl/fir_stream_controller_if.sv
// ----------------------------------------------------------------------------
// fir_stream_controller_if
//
// Purpose : valid/ready sample stream between a sample source and the FIR
//           run controller.
// Signals : sampleIn    - signed sample, driven by the source
//           sampleValid - sampleIn is valid, driven by the source
//           sampleReady - consumer can take a sample this cycle
// Modports: master = sample source, slave = controller.
// ----------------------------------------------------------------------------
interface fir_stream_controller_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic signed [DATA_WIDTH-1:0] sampleIn;
    logic                         sampleValid;
    logic                         sampleReady;

    modport master (
        output sampleIn,
        output sampleValid,
        input  sampleReady
    );

    modport slave (
        input  sampleIn,
        input  sampleValid,
        output sampleReady
    );

endinterface

// File: rtl/fir_stream_controller_valid_delay_line.sv
// ----------------------------------------------------------------------------
// valid_delay_line
//
// Purpose : 1-bit shift register that delays the FIR shift-enable so the
//           "this output is a real convolution term" flag lines up with the
//           registered FIR output.
// Ports   : clock     - rising-edge clock
//           reset     - synchronous, active-high; empties the line
//           validIn   - bit shifted in each cycle
//           validOut  - oldest bit (DEPTH cycles after validIn)
//           lineEmpty - no bit is in flight anywhere in the line
// ----------------------------------------------------------------------------
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic validIn,
    output logic validOut,
    output logic lineEmpty
);

    logic [DEPTH-1:0] line;

    // Shift toward the MSB; the shift form also works for DEPTH == 1.
    always_ff @(posedge clock) begin
        if (reset) begin
            line <= '0;
        end else begin
            line <= (line << 1) | DEPTH'(validIn);
        end
    end

    assign validOut  = line[DEPTH-1];
    assign lineEmpty = (line == '0);

endmodule

// File: rtl/fir_stream_controller.sv
// ----------------------------------------------------------------------------
// fir_stream_controller
//
// Purpose : sequences one FIR run of n_tap_fir. Triggers the coefficient load
//           once per reset, streams numSamples input samples into the FIR,
//           appends LENGTH-1 zero pads for a full convolution, tracks the FIR
//           latency so dataOutValid marks every convolution term, and pulses
//           done at the end of the run.
// Ports   : clock, reset       - rising-edge clock, synchronous active-high reset
//           start, numSamples  - run request and sample count (taken in IDLE)
//           sampleBus          - valid/ready sample stream (slave side)
//           enableFIRCoeff     - enable to setup_FIR_coeff
//           coeffSetFlag       - coefficients loaded, from setup_FIR_coeff
//           loadDataFlag       - per-cycle shift enable to n_tap_fir
//           stopDataLoadFlag   - high in DONE
//           firDataIn          - sample / pad value to n_tap_fir
//           firDataOut         - FIR result from n_tap_fir
//           dataOut            - registered copy of firDataOut
//           dataOutValid       - dataOut holds a convolution term
//           busy, done         - run in progress / one-cycle end-of-run pulse
//           outCount           - dataOutValid pulses of the current run
//                                (only with FIR_CTRL_STATUS_EN defined)
// Config  : FIR_CTRL_STATUS_EN adds the outCount status counter and port.
// ----------------------------------------------------------------------------
module fir_stream_controller
    import fir_stream_controller_pkg::*;
#(
    parameter int LENGTH      = 20,
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16,
    parameter int FIR_LATENCY = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [COUNT_WIDTH-1:0]         numSamples,
    fir_stream_controller_if.slave         sampleBus,
    output logic                           enableFIRCoeff,
    input  logic                           coeffSetFlag,
    output logic                           loadDataFlag,
    output logic                           stopDataLoadFlag,
    output logic signed [DATA_WIDTH-1:0]   firDataIn,
    input  logic signed [2*DATA_WIDTH-1:0] firDataOut,
    output logic signed [2*DATA_WIDTH-1:0] dataOut,
    output logic                           dataOutValid,
    output logic                           busy,
    output logic                           done
`ifdef FIR_CTRL_STATUS_EN
    ,
    output logic [COUNT_WIDTH:0]           outCount
`endif
);

    localparam int PAD_CYCLES = padCycles(LENGTH);

    fir_ctrl_state_e state;
    fir_ctrl_state_e stateNext;

    logic [COUNT_WIDTH-1:0] numLatched;
    logic [COUNT_WIDTH-1:0] sampleCount;
    logic [COUNT_WIDTH-1:0] padCount;
    logic                   coeffLoaded;
    logic                   transfer;
    logic                   lastSample;
    logic                   lastPad;
    logic                   lineEmpty;

    // State-decoded outputs; the state is registered so these are clean.
    assign sampleBus.sampleReady = (state == STREAM);
    assign enableFIRCoeff        = (state == COEFF);
    assign stopDataLoadFlag      = (state == DONE);
    assign done                  = (state == DONE);
    assign busy                  = (state != IDLE);

    assign transfer   = (state == STREAM) && sampleBus.sampleValid;
    // STREAM is only entered with numLatched >= 1, so the subtraction is safe.
    assign lastSample = transfer && (sampleCount == numLatched - COUNT_WIDTH'(1));
    assign lastPad    = (padCount == COUNT_WIDTH'(PAD_CYCLES - 1));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic. DRAIN also waits for loadDataFlag itself, because the
    // last pad's shift enable is still on its way into the delay line.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!coeffLoaded) begin
                        stateNext = COEFF;
                    end else if (numSamples == '0) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = STREAM;
                    end
                end
            end
            COEFF: begin
                if (coeffSetFlag) begin
                    stateNext = (numLatched == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (lastSample) begin
                    stateNext = (PAD_CYCLES == 0) ? DRAIN : PAD;
                end
            end
            PAD: begin
                if (lastPad) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (!loadDataFlag && lineEmpty) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Run bookkeeping: sample count latch, counters and the once-per-reset
    // coefficient flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            numLatched  <= '0;
            sampleCount <= '0;
            padCount    <= '0;
            coeffLoaded <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                numLatched  <= numSamples;
                sampleCount <= '0;
                padCount    <= '0;
            end
            if (state == COEFF && coeffSetFlag) begin
                coeffLoaded <= 1'b1;
            end
            if (transfer) begin
                sampleCount <= sampleCount + COUNT_WIDTH'(1);
            end
            if (state == PAD) begin
                padCount <= padCount + COUNT_WIDTH'(1);
            end
        end
    end

    // FIR-facing datapath. A shift enable is issued only for a real transfer
    // or a pad; during bubbles firDataIn simply holds its last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            firDataIn    <= '0;
            loadDataFlag <= 1'b0;
            dataOut      <= '0;
        end else begin
            dataOut      <= firDataOut;
            loadDataFlag <= 1'b0;
            if (transfer) begin
                firDataIn    <= sampleBus.sampleIn;
                loadDataFlag <= 1'b1;
            end else if (state == PAD) begin
                firDataIn    <= '0;
                loadDataFlag <= 1'b1;
            end
        end
    end

    // One extra stage beyond the FIR latency covers the dataOut register.
    valid_delay_line #(
        .DEPTH(FIR_LATENCY + 1)
    ) validLine (
        .clock    (clock),
        .reset    (reset),
        .validIn  (loadDataFlag),
        .validOut (dataOutValid),
        .lineEmpty(lineEmpty)
    );

`ifdef FIR_CTRL_STATUS_EN
    // Output-term counter; cleared by an accepted start, held after DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            outCount <= '0;
        end else if (state == IDLE && start) begin
            outCount <= '0;
        end else if (dataOutValid) begin
            outCount <= outCount + (COUNT_WIDTH + 1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fir_stream_controller.sv
// ----------------------------------------------------------------------------
// tb_fir_stream_controller
//
// Purpose : directed bench for fir_stream_controller with LENGTH=20,
//           DATA_WIDTH=8, FIR_LATENCY=1. Surrounds the controller with a
//           behavioural coefficient loader and a registered 20-tap FIR whose
//           coefficients are 1..20. Expected convolution terms are computed
//           directly from the sample list and queued when a run is started;
//           each dataOutValid pops and compares one term.
// Config  : FIR_CTRL_STATUS_EN also checks the outCount status port.
// ----------------------------------------------------------------------------
module tb_fir_stream_controller;

    localparam int LENGTH      = 20;
    localparam int DATA_WIDTH  = 8;
    localparam int COUNT_WIDTH = 16;
    localparam int FIR_LATENCY = 1;

    logic                           clock = 1'b0;
    logic                           reset = 1'b1;
    logic                           start = 1'b0;
    logic [COUNT_WIDTH-1:0]         numSamples = '0;
    logic                           enableFIRCoeff;
    logic                           coeffSetFlag;
    logic                           loadDataFlag;
    logic                           stopDataLoadFlag;
    logic signed [DATA_WIDTH-1:0]   firDataIn;
    logic signed [2*DATA_WIDTH-1:0] firDataOut;
    logic signed [2*DATA_WIDTH-1:0] dataOut;
    logic                           dataOutValid;
    logic                           busy;
    logic                           done;
`ifdef FIR_CTRL_STATUS_EN
    logic [COUNT_WIDTH:0]           outCount;
`endif

    fir_stream_controller_if #(.DATA_WIDTH(DATA_WIDTH)) sampleBus ();

    fir_stream_controller #(
        .LENGTH     (LENGTH),
        .DATA_WIDTH (DATA_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH),
        .FIR_LATENCY(FIR_LATENCY)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .numSamples      (numSamples),
        .sampleBus       (sampleBus.slave),
        .enableFIRCoeff  (enableFIRCoeff),
        .coeffSetFlag    (coeffSetFlag),
        .loadDataFlag    (loadDataFlag),
        .stopDataLoadFlag(stopDataLoadFlag),
        .firDataIn       (firDataIn),
        .firDataOut      (firDataOut),
        .dataOut         (dataOut),
        .dataOutValid    (dataOutValid),
        .busy            (busy),
        .done            (done)
`ifdef FIR_CTRL_STATUS_EN
        ,
        .outCount        (outCount)
`endif
    );

    always #5 clock = ~clock;

    // Coefficient loader stand-in: acknowledges after enable has been seen
    // for four edges, so enableFIRCoeff stays high for five cycles.
    int coeffCnt;
    always @(posedge clock) begin
        if (reset || !enableFIRCoeff) begin
            coeffCnt     <= 0;
            coeffSetFlag <= 1'b0;
        end else begin
            coeffCnt     <= coeffCnt + 1;
            coeffSetFlag <= (coeffCnt >= 3);
        end
    end

    // Registered FIR stand-in, coefficient of tap k is k+1.
    logic signed [DATA_WIDTH-1:0] firHist [0:LENGTH-2];
    always @(posedge clock) begin : firModel
        int acc;
        if (reset) begin
            for (int k = 0; k < LENGTH - 1; k++) firHist[k] <= '0;
            firDataOut <= '0;
        end else if (loadDataFlag) begin
            acc = int'(firDataIn);
            for (int k = 1; k < LENGTH; k++) acc += (k + 1) * int'(firHist[k-1]);
            firDataOut <= 16'(acc);
            firHist[0] <= firDataIn;
            for (int k = 1; k < LENGTH - 1; k++) firHist[k] <= firHist[k-1];
        end
    end

    int checkCount = 0;
    int errorCount = 0;
    int validSeen  = 0;
    int loadSeen   = 0;
    int doneSeen   = 0;
    int enableSeen = 0;
    logic                         prevReady = 1'b0;
    logic                         prevValid = 1'b0;
    logic signed [DATA_WIDTH-1:0] prevSample = '0;
    logic signed [DATA_WIDTH-1:0] sampleMem [0:63];
    logic signed [15:0]           expQ [$];

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Full convolution of sampleMem[0..n-1] with coefficients 1..LENGTH.
    task automatic pushExpected(input int n);
        int acc;
        if (n > 0) begin
            for (int i = 0; i < n + LENGTH - 1; i++) begin
                acc = 0;
                for (int k = 0; k < LENGTH; k++) begin
                    if (i - k >= 0 && i - k < n) acc += (k + 1) * int'(sampleMem[i-k]);
                end
                expQ.push_back(16'(acc));
            end
        end
    endtask

    // One cycle: observe outputs at the falling edge, then drive the source.
    task automatic stepCycle(input logic v, input logic signed [DATA_WIDTH-1:0] s);
        logic signed [15:0] expected;
        @(negedge clock);
        if (dataOutValid === 1'b1) begin
            validSeen++;
            checkOutput("validHasExpected", 32'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                expected = expQ.pop_front();
                checkOutput("dataOut", 32'(dataOut), 32'(expected));
            end
        end
        if (loadDataFlag === 1'b1) loadSeen++;
        if (done === 1'b1) doneSeen++;
        if (enableFIRCoeff === 1'b1) enableSeen++;
        if (prevReady) begin
            checkOutput("loadFlag", 32'(loadDataFlag), 32'(prevValid));
            if (prevValid) checkOutput("firDataIn", 32'(firDataIn), 32'(prevSample));
        end
        sampleBus.sampleValid = v;
        sampleBus.sampleIn    = s;
        prevReady  = (sampleBus.sampleReady === 1'b1);
        prevValid  = v;
        prevSample = s;
    endtask

    task automatic checkResetOutputs(input string tag);
        $display("[TB] reset output check: %s", tag);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstReady", 32'(sampleBus.sampleReady), 0);
        checkOutput("rstEnable", 32'(enableFIRCoeff), 0);
        checkOutput("rstLoad", 32'(loadDataFlag), 0);
        checkOutput("rstStop", 32'(stopDataLoadFlag), 0);
        checkOutput("rstFirIn", 32'(firDataIn), 0);
        checkOutput("rstDataOut", 32'(dataOut), 0);
        checkOutput("rstValid", 32'(dataOutValid), 0);
    endtask

    // Runs one complete FIR run of n samples and checks its totals.
    task automatic applyStimulus(input int n, input bit toggle, input bit padStart,
                                 input bit expectCoeff);
        int   doneBase, validBase, loadBase, enableBase, idx, cyc, expectedTerms;
        logic v;
        $display("[TB] run: n=%0d toggle=%0d padStart=%0d coeff=%0d", n, toggle, padStart, expectCoeff);
        doneBase      = doneSeen;
        validBase     = validSeen;
        loadBase      = loadSeen;
        enableBase    = enableSeen;
        expectedTerms = (n > 0) ? n + LENGTH - 1 : 0;
        pushExpected(n);
        stepCycle(1'b0, '0);
        start      = 1'b1;
        numSamples = COUNT_WIDTH'(n);
        stepCycle(1'b0, '0);
        start = 1'b0;
        checkOutput("busyAfterStart", 32'(busy), 1);
        if (expectCoeff)  checkOutput("coeffEnable", 32'(enableFIRCoeff), 1);
        else if (n > 0)   checkOutput("streamDirect", 32'(sampleBus.sampleReady), 1);
        else              checkOutput("zeroRunDone", 32'(done), 1);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 4 * n + 100) begin
            v = toggle ? logic'(cyc % 2 == 0) : 1'b1;
            if (v) stepCycle(1'b1, sampleMem[idx]);
            else   stepCycle(1'b0, -8'sd77);
            if (sampleBus.sampleReady === 1'b1 && v) idx++;
            cyc++;
        end
        checkOutput("samplesAccepted", idx, n);
        if (padStart) begin
            repeat (3) stepCycle(1'b0, '0);
            start      = 1'b1;
            numSamples = COUNT_WIDTH'(9);
            stepCycle(1'b0, '0);
            start = 1'b0;
            checkOutput("padStartNoCoeff", 32'(enableFIRCoeff), 0);
            checkOutput("padStartNoReady", 32'(sampleBus.sampleReady), 0);
        end
        cyc = 0;
        while (doneSeen == doneBase && cyc < 400) begin
            stepCycle(1'b0, '0);
            cyc++;
        end
        checkOutput("doneReached", doneSeen - doneBase, 1);
        repeat (3) stepCycle(1'b0, '0);
        checkOutput("donePulses", doneSeen - doneBase, 1);
        checkOutput("validPulses", validSeen - validBase, expectedTerms);
        checkOutput("loadPulses", loadSeen - loadBase, expectedTerms);
        checkOutput("coeffEnableCycles", enableSeen - enableBase, expectCoeff ? 5 : 0);
        checkOutput("scoreboardLeft", expQ.size(), 0);
        checkOutput("idleAfterDone", 32'(busy), 0);
`ifdef FIR_CTRL_STATUS_EN
        checkOutput("outCount", 32'(outCount), expectedTerms);
`endif
        expQ.delete();
    endtask

    initial begin
        int idx;
        int cyc;
        for (int i = 0; i < 64; i++) sampleMem[i] = 8'((i * 37 + 11) % 256 - 128);
        sampleMem[0] = -8'sd128;
        sampleMem[1] = 8'sd127;
        sampleBus.sampleValid = 1'b0;
        sampleBus.sampleIn    = '0;

        // Reset state.
        repeat (3) stepCycle(1'b0, '0);
        checkResetOutputs("power-on");
        reset = 1'b0;
        stepCycle(1'b0, '0);

        // 33 samples with coefficient load, continuous valid.
        applyStimulus(33, 1'b0, 1'b0, 1'b1);

        // Impulse: outputs equal the coefficients 1..20.
        sampleMem[0] = 8'sd1;
        applyStimulus(1, 1'b0, 1'b0, 1'b0);
        sampleMem[0] = -8'sd128;

        // Same 33 samples with a bubble every other cycle.
        applyStimulus(33, 1'b1, 1'b0, 1'b0);

        // Zero-length run: IDLE -> DONE -> IDLE.
        applyStimulus(0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of STREAM after 10 samples.
        pushExpected(33);
        stepCycle(1'b0, '0);
        start      = 1'b1;
        numSamples = COUNT_WIDTH'(33);
        stepCycle(1'b0, '0);
        start = 1'b0;
        checkOutput("midRunStream", 32'(sampleBus.sampleReady), 1);
        idx = 0;
        cyc = 0;
        while (idx < 10 && cyc < 100) begin
            stepCycle(1'b1, sampleMem[idx]);
            if (sampleBus.sampleReady === 1'b1) idx++;
            cyc++;
        end
        stepCycle(1'b0, '0);
        reset = 1'b1;
        stepCycle(1'b0, '0);
        reset = 1'b0;
        checkResetOutputs("mid-run");
        expQ.delete();
        applyStimulus(2, 1'b0, 1'b0, 1'b1);

        // Start during PAD is ignored; the next run skips COEFF.
        applyStimulus(5, 1'b0, 1'b1, 1'b0);
        applyStimulus(3, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
